// File: rtl/mul.sv
// mul -- sequential shift-add multiplier, W x W -> 2W bits.
//
// A master pulses `start` for one cycle while the block is idle. The block
// then processes one multiplier bit per clock, LSB first. W cycles later it
// loads the product into `P` and pulses `done` for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, honoured only while busy = 0
//   a      multiplicand, captured on the accepting edge
//   b      multiplier, captured on the accepting edge
//   busy   high while a multiplication is in progress
//   done   one-cycle pulse: P has just been updated
//   P      product register, held until the next completion
//
// Compile-time option:
//   MUL_SIGNED_EN  defined   -> a, b and P are two's complement
//                  undefined -> unsigned operation (default)
module mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  // The counter must be able to hold the value W itself.
  localparam int CW = $clog2(W + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [2*W-1:0]  acc_r;
  logic [2*W-1:0]  acc_next_s;
  logic [W:0]      hi_s;
  logic [W:0]      addend_s;
  logic [W:0]      sum_s;
  logic            last_s;
  logic            busy_r;
  logic            done_r;
  logic [2*W-1:0]  p_r;

  assign busy = busy_r;
  assign done = done_r;
  assign P    = p_r;

  // The iteration that consumes the multiplier MSB is the one that finishes.
  assign last_s = (cnt_r == CW'(1));

  // Next-state logic: leave IDLE on start, return when the final bit is done.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One shift-add step. The upper half is widened to W+1 bits so the carry
  // (unsigned) or the sign (signed) survives the shift.
  always_comb begin
    hi_s       = '0;
    addend_s   = '0;
    sum_s      = '0;
    acc_next_s = '0;
`ifdef MUL_SIGNED_EN
    hi_s     = {acc_r[2*W-1], acc_r[2*W-1:W]};
    addend_s = {a_r[W-1], a_r};
    if (b_r[0]) begin
      // The multiplier MSB carries negative weight, so the last partial
      // product is subtracted rather than added.
      if (last_s) begin
        sum_s = hi_s - addend_s;
      end else begin
        sum_s = hi_s + addend_s;
      end
    end else begin
      sum_s = hi_s;
    end
`else
    hi_s     = {1'b0, acc_r[2*W-1:W]};
    addend_s = {1'b0, a_r};
    if (b_r[0]) begin
      sum_s = hi_s + addend_s;
    end else begin
      sum_s = hi_s;
    end
`endif
    // The sum's W+1 bits become the new top of the accumulator, which is
    // the same as adding into the upper half and shifting right by one.
    acc_next_s = {sum_s, acc_r[W-1:1]};
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and output registers: capture operands, iterate, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            acc_r  <= '0;
            cnt_r  <= CW'(W);
            busy_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          b_r   <= {1'b0, b_r[W-1:1]};
          cnt_r <= cnt_r - CW'(1);
          if (last_s) begin
            p_r    <= acc_next_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            done_r <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
// Testbench for mul (W = 4). Each stimulus pushes its expected product onto a
// queue. An independent monitor pops one entry and compares it with P at every
// done pulse.
module tb_mul;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [2*W-1:0] P;

  int tests;
  int fails;
  logic [2*W-1:0] exp_q[$];

  mul #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [2*W-1:0] exp_v;
    if (!rst && done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done got P=%02h want no done", P);
      end else begin
        exp_v = exp_q.pop_front();
        if (P !== exp_v) begin
          fails++;
          $display("FAIL product got=%02h want=%02h", P, exp_v);
        end
      end
    end
  end

  // Issue one multiply from a negedge and wait (bounded) for its done pulse,
  // checking latency and that busy stays high until completion.
  task automatic do_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] ev, input string nm);
    bit seen;
    bit busy_bad;
    int lat;
    seen = 1'b0;
    busy_bad = 1'b0;
    lat = 0;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(ev);
    for (int i = 1; i <= W + 4 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat = i;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout got no done want done within %0d cycles", nm, W + 4);
    end else if (lat != W + 1) begin
      fails++;
      $display("FAIL %s_latency got %0d want %0d", nm, lat, W + 1);
    end
    tests++;
    if (busy_bad || busy) begin
      fails++;
      $display("FAIL %s_busy got glitch=%0d busy_at_done=%0d want 0 0", nm, busy_bad, busy);
    end
  endtask

  task automatic check_val(input string nm, input logic [2*W-1:0] got,
                           input logic [2*W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  initial begin
    bit seen;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check_val("reset_P", P, 8'h00);
    check_val("reset_busy", {7'h00, busy}, 8'h00);
    check_val("reset_done", {7'h00, done}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    do_mul(4'h0, 4'h1, 8'h00, "zero");

`ifdef MUL_SIGNED_EN
    do_mul(4'h8, 4'h8, 8'h40, "neg8_neg8");
    do_mul(4'hF, 4'h7, 8'hF9, "neg1_7");
    do_mul(4'h7, 4'h8, 8'hC8, "7_neg8");
    do_mul(4'h3, 4'h4, 8'h0C, "3_4");
`else
    // Back-to-back sweep: each call starts on the cycle done is seen.
    for (int i = 1; i <= 15; i++) begin
      do_mul(4'(i - 1), 4'(i), 8'((i - 1) * i), "sweep");
    end
    do_mul(4'hF, 4'hF, 8'hE1, "15_15");
    do_mul(4'h7, 4'h9, 8'h3F, "b2b_7_9");
`endif

    // A start that arrives while busy, and operand changes, must be ignored.
    @(negedge clk);
    a = 4'h5;
    b = 4'h6;
    start = 1'b1;
    exp_q.push_back(8'h1E);
    seen = 1'b0;
    for (int i = 1; i <= W + 4 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a = 4'h2;
        b = 4'h2;
      end else if (i == 2) begin
        start = 1'b1;
      end else if (i == 3) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL busy_ignore_timeout got no done want done");
    end
    repeat (W + 3) @(negedge clk);

    // Reset two cycles into an operation aborts it and clears P.
    a = 4'hD;
    b = 4'hB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_P", P, 8'h00);
    check_val("midrst_busy", {7'h00, busy}, 8'h00);
    check_val("midrst_done", {7'h00, done}, 8'h00);
    @(negedge clk);
    // start coincident with reset release is honoured on the first edge.
    rst = 1'b0;
    do_mul(4'h3, 4'h5, 8'h0F, "start_at_release");
    repeat (W + 3) @(negedge clk);

    check_val("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
